// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state and note-stack entry type
// for the channel tracker and its note stack.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PB       = 4'hE;

  localparam logic [6:0] CC_MOD       = 7'd1;
  localparam logic [6:0] CC_RESET_ALL = 7'd121;
  localparam logic [6:0] CC_ALL_OFF   = 7'd123;

  localparam logic [8:0] PB_CENTER_9 = 9'd256;

  typedef enum logic [1:0] {
    IDLE,
    D1,
    D2
  } parse_state_t;

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] vel;
  } note_ent_t;

  function automatic logic is_tracked(input logic [3:0] t);
    return (t == NOTE_OFF) || (t == NOTE_ON) ||
           (t == CC) || (t == PB);
  endfunction

endpackage

// File: rtl/midi_note_stack.sv
// Last-note-priority stack: index 0 is the oldest entry, count-1 the top.
// Removal compacts the array; overflow drops the oldest entry.
module midi_note_stack
  import midi_pkg::*;
#(
  parameter int NOTE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_remove,
  input  logic       i_clear,
  input  logic [6:0] i_note,
  input  logic [6:0] i_vel,
  output logic [6:0] o_top,
  output logic [6:0] o_top_vel,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_ovf
);

  localparam int CW = $clog2(NOTE_DEPTH + 1);
  localparam int IW = $clog2(NOTE_DEPTH);

  note_ent_t         r_ent [NOTE_DEPTH];
  logic [CW-1:0]     r_cnt;
  logic [6:0]        r_top;
  logic [6:0]        r_top_vel;
  logic              r_ovf;

  note_ent_t         w_ent [NOTE_DEPTH];
  logic [CW-1:0]     w_cnt;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_topi;
  logic              w_hit;
  logic              w_full;
  logic              w_rm;

  always_comb begin
    w_full = (r_cnt == CW'(NOTE_DEPTH));
    w_hit  = 1'b0;
    w_idx  = '0;
    for (int i = 0; i < NOTE_DEPTH; i++) begin
      if (!w_hit && (CW'(i) < r_cnt) &&
          (r_ent[i].note == i_note)) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
    // A full push with no hit removes index 0, i.e. the oldest entry.
    w_rm  = (i_push && (w_hit || w_full)) ||
            (i_remove && w_hit);
    w_ent = r_ent;
    w_cnt = r_cnt;
    if (i_clear) begin
      w_cnt = '0;
    end else begin
      if (w_rm) begin
        for (int i = 0; i < NOTE_DEPTH - 1; i++) begin
          if (IW'(i) >= w_idx)
            w_ent[i] = r_ent[i+1];
        end
        w_cnt = r_cnt - CW'(1);
      end
      if (i_push) begin
        w_ent[w_cnt[IW-1:0]] = {i_note, i_vel};
        w_cnt = w_cnt + CW'(1);
      end
    end
    w_topi = IW'(w_cnt - CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent     <= '{default: '0};
      r_cnt     <= '0;
      r_top     <= '0;
      r_top_vel <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ent <= w_ent;
      r_cnt <= w_cnt;
      r_ovf <= i_push && !i_clear && w_full && !w_hit;
      if (w_cnt != '0) begin
        r_top     <= w_ent[w_topi].note;
        r_top_vel <= w_ent[w_topi].vel;
      end
    end
  end

  assign o_top     = r_top;
  assign o_top_vel = r_top_vel;
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(NOTE_DEPTH));
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/midi_chan_tracker.sv
// Single-channel MIDI running-status parser feeding a note stack;
// presents steady note/vel/pb/cc1 levels to the echo generator and voice.
module midi_chan_tracker
  import midi_pkg::*;
#(
  parameter int NOTE_DEPTH = 4,
  parameter int PB_SHIFT   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_valid,
  input  logic [7:0] midi_data,
  input  logic [3:0] channel,
  output logic       note_on,
  output logic       note_repeat,
  output logic [6:0] note,
  output logic [6:0] vel,
  output logic [8:0] pb,
  output logic [1:0] cc1,
  output logic       stack_ovf
);

  parse_state_t r_state;
  logic [3:0]   r_type;
  logic [6:0]   r_d1;
  logic [8:0]   r_pb;
  logic [1:0]   r_cc1;
  logic         r_rep;

  logic         w_rt;
  logic         w_sys;
  logic         w_chan;
  logic         w_data;
  logic         w_match;
  logic         w_exec;
  logic         w_on;
  logic         w_off;
  logic         w_clear;
  logic [6:0]   w_d2;
  logic [13:0]  w_bend;
  logic [8:0]   w_pb;
  logic [6:0]   w_top;
  logic [6:0]   w_top_vel;
  logic         w_empty;
  logic         w_full;
  logic         w_ovf;

  assign w_rt    = (midi_data[7:3] == 5'b11111);
  assign w_sys   = (midi_data[7:3] == 5'b11110);
  assign w_chan  = midi_data[7] && (midi_data[7:4] != 4'hF);
  assign w_data  = !midi_data[7];
  assign w_match = (midi_data[3:0] == channel) &&
                   is_tracked(midi_data[7:4]);

  assign w_d2    = midi_data[6:0];
  assign w_exec  = midi_valid && w_data && (r_state == D2);
  assign w_on    = w_exec && (r_type == NOTE_ON) && (w_d2 != '0);
  assign w_off   = w_exec && ((r_type == NOTE_OFF) ||
                   ((r_type == NOTE_ON) && (w_d2 == '0)));
  assign w_clear = w_exec && (r_type == CC) && (r_d1 == CC_ALL_OFF);
  assign w_bend  = {w_d2, r_d1};
  assign w_pb    = 9'(w_bend >> PB_SHIFT);

  midi_note_stack #(
    .NOTE_DEPTH(NOTE_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_on),
    .i_remove (w_off),
    .i_clear  (w_clear),
    .i_note   (r_d1),
    .i_vel    (w_d2),
    .o_top    (w_top),
    .o_top_vel(w_top_vel),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_type  <= '0;
      r_d1    <= '0;
      r_pb    <= PB_CENTER_9;
      r_cc1   <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_rep <= w_on && !w_empty && (r_d1 == w_top);
      if (midi_valid) begin
        unique case (1'b1)
          w_rt: ;
          w_sys: r_state <= IDLE;
          w_chan: begin
            if (w_match) begin
              r_type  <= midi_data[7:4];
              r_state <= D1;
            end else begin
              r_state <= IDLE;
            end
          end
          w_data: begin
            unique case (r_state)
              D1: begin
                r_d1    <= w_d2;
                r_state <= D2;
              end
              D2: begin
                // Running status: stay armed for the next data pair.
                r_state <= D1;
                if (r_type == CC) begin
                  if (r_d1 == CC_MOD) begin
                    r_cc1 <= w_d2[6:5];
                  end else if (r_d1 == CC_RESET_ALL) begin
                    r_pb  <= PB_CENTER_9;
                    r_cc1 <= '0;
                  end
                end else if (r_type == PB) begin
                  r_pb <= w_pb;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign note_on     = !w_empty;
  assign note_repeat = r_rep;
  assign note        = w_top;
  assign vel         = w_top_vel;
  assign pb          = r_pb;
  assign cc1         = r_cc1;
  assign stack_ovf   = w_ovf && w_full;

endmodule

// File: tb/tb_midi_chan_tracker.sv
// Directed and randomized byte streams checked against a queue-based
// model of the channel tracker.
module tb_midi_chan_tracker;

  localparam int DEPTH = 4;
  localparam int SHIFT = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       midi_valid;
  logic [7:0] midi_data;
  logic [3:0] channel;
  logic       note_on;
  logic       note_repeat;
  logic [6:0] note;
  logic [6:0] vel;
  logic [8:0] pb;
  logic [1:0] cc1;
  logic       stack_ovf;

  always #5 clk = ~clk;

  midi_chan_tracker #(
    .NOTE_DEPTH(DEPTH),
    .PB_SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .midi_valid (midi_valid),
    .midi_data  (midi_data),
    .channel    (channel),
    .note_on    (note_on),
    .note_repeat(note_repeat),
    .note       (note),
    .vel        (vel),
    .pb         (pb),
    .cc1        (cc1),
    .stack_ovf  (stack_ovf)
  );

  typedef struct {
    int note;
    int vel;
  } ent_t;

  int   n_checks = 0;
  int   n_err    = 0;
  ent_t m_stk[$];
  int   m_need, m_type, m_d1;
  int   m_note, m_vel, m_pb, m_cc1;
  bit   m_rep, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " note_on"}, 32'(note_on), 32'(m_stk.size() > 0));
    chk({tag, " note"}, 32'(note), m_note);
    chk({tag, " vel"}, 32'(vel), m_vel);
    chk({tag, " pb"}, 32'(pb), m_pb);
    chk({tag, " cc1"}, 32'(cc1), m_cc1);
    chk({tag, " note_repeat"}, 32'(note_repeat), 32'(m_rep));
    chk({tag, " stack_ovf"}, 32'(stack_ovf), 32'(m_ovf));
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_need = 0; m_type = 0; m_d1 = 0;
    m_note = 0; m_vel = 0; m_pb = 256; m_cc1 = 0;
    m_rep = 0; m_ovf = 0;
  endtask

  task automatic remove_note(input int n);
    for (int i = 0; i < m_stk.size(); i++) begin
      if (m_stk[i].note == n) begin
        m_stk.delete(i);
        break;
      end
    end
  endtask

  task automatic execute(input int t, input int d1, input int d2);
    ent_t e;
    if (t == 9 && d2 > 0) begin
      if (m_stk.size() > 0 && m_stk[$].note == d1) m_rep = 1;
      remove_note(d1);
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        m_ovf = 1;
      end
      e.note = d1;
      e.vel  = d2;
      m_stk.push_back(e);
    end else if (t == 8 || t == 9) begin
      remove_note(d1);
    end else if (t == 11) begin
      if (d1 == 1) m_cc1 = d2 / 32;
      else if (d1 == 121) begin m_pb = 256; m_cc1 = 0; end
      else if (d1 == 123) m_stk.delete();
    end else if (t == 14) begin
      m_pb = (d2 * 128 + d1) / (1 << SHIFT);
    end
    if (m_stk.size() > 0) begin
      m_note = m_stk[$].note;
      m_vel  = m_stk[$].vel;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    m_rep = 0;
    m_ovf = 0;
    t = int'(b[7:4]);
    if (b >= 8'hF8) begin
    end else if (b >= 8'hF0) begin
      m_need = 0;
    end else if (b >= 8'h80) begin
      if (b[3:0] == channel && (t == 8 || t == 9 || t == 11 || t == 14)) begin
        m_type = t;
        m_need = 1;
      end else begin
        m_need = 0;
      end
    end else if (m_need == 1) begin
      m_d1 = int'(b);
      m_need = 2;
    end else if (m_need == 2) begin
      execute(m_type, m_d1, int'(b));
      m_need = 1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    midi_valid = 1'b1;
    midi_data  = b;
    @(posedge clk);
    #1;
    midi_valid = 1'b0;
    model_byte(b);
    check_all($sformatf("byte %02h", b));
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    send(a);
    send(b);
    send(c);
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
    m_rep = 0;
    m_ovf = 0;
    check_all("idle");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 model_reset();
    check_all("async reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    midi_valid = 1'b0;
    midi_data  = 8'h00;
    channel    = 4'd0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset pb", 32'(pb), 256);
    @(negedge clk);
    reset = 1'b0;

    send3(8'h90, 8'h3C, 8'h64);
    chk("tp1 note", 32'(note), 60);
    chk("tp1 vel", 32'(vel), 100);
    send3(8'h80, 8'h3C, 8'h00);
    chk("tp1 off", 32'(note_on), 0);
    chk("tp1 hold", 32'(note), 60);

    send3(8'h90, 8'h3C, 8'h64);
    send(8'h40); send(8'h50);
    chk("tp2 note", 32'(note), 64);
    chk("tp2 vel", 32'(vel), 80);
    send(8'h3C); send(8'h00);
    chk("tp2 top", 32'(note), 64);
    send(8'h40); send(8'h00);
    chk("tp2 off", 32'(note_on), 0);

    send3(8'h90, 8'h3C, 8'h64);
    send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64);
    send(8'h41); send(8'h64);
    send(8'h43); send(8'h64);
    chk("tp3 ovf", 32'(stack_ovf), 1);
    send3(8'h80, 8'h43, 8'h00);
    send(8'h41); send(8'h00);
    send(8'h40); send(8'h00);
    send(8'h3E); send(8'h00);
    chk("tp3 empty", 32'(note_on), 0);

    send3(8'hE0, 8'h00, 8'h40);
    chk("pb centre", 32'(pb), 256);
    send3(8'hE0, 8'h7F, 8'h7F);
    chk("pb max", 32'(pb), 511);
    send3(8'hB0, 8'h01, 8'h7F);
    chk("cc1 max", 32'(cc1), 3);
    send3(8'hB0, 8'h79, 8'h00);
    chk("reset-all pb", 32'(pb), 256);
    chk("reset-all cc1", 32'(cc1), 0);

    send3(8'h91, 8'h3C, 8'h64);
    chk("foreign chan", 32'(note_on), 0);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    chk("realtime mid", 32'(note), 60);
    chk("realtime on", 32'(note_on), 1);

    send3(8'hB0, 8'h7B, 8'h00);
    send3(8'h90, 8'h3C, 8'h64);
    chk("no repeat", 32'(note_repeat), 0);
    send3(8'h90, 8'h3C, 8'h64);
    chk("repeat", 32'(note_repeat), 1);
    idle();
    send(8'h90); send(8'h3E);
    do_reset();
    send(8'h64);
    chk("orphan", 32'(note_on), 0);

    send(8'h90);
    channel = 4'd1;
    send(8'h45); send(8'h33);
    chk("chan change", 32'(note), 69);
    send3(8'h91, 8'h46, 8'h22);
    chk("new chan", 32'(note), 70);
    channel = 4'd0;

    for (int it = 0; it < 3000; it++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        idle();
      end else if (r < 10) begin
        do_reset();
      end else if (r < 13) begin
        channel = 4'($urandom_range(0, 1));
      end else if (r < 35) begin
        case ($urandom_range(0, 6))
          0: b = 8'h90;
          1: b = 8'h80;
          2: b = 8'hB0;
          3: b = 8'hE0;
          4: b = 8'hA0;
          5: b = 8'hC0;
          default: b = 8'h90;
        endcase
        b[0] = ($urandom_range(0, 3) == 0);
        send(b);
      end else if (r < 40) begin
        b = 8'($urandom_range(8'hF0, 8'hFF));
        send(b);
      end else begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'h00;
          2:       b = 8'h01;
          3:       b = 8'h79;
          4:       b = 8'h7B;
          5, 6:    b = 8'($urandom_range(0, 127));
          default: b = 8'($urandom_range(60, 65));
        endcase
        send(b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
